// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle control path: opcodes, FSM states,
// PC / register-file write-data / ALU selects.
package risc16_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt,
      StError
   } state_e;

   localparam logic [1:0] PC_PLUS1     = 2'b00;
   localparam logic [1:0] PC_PLUS1_IMM = 2'b01;
   localparam logic [1:0] PC_ALU       = 2'b10;

   localparam logic [1:0] RF_ALU = 2'b00;
   localparam logic [1:0] RF_MEM = 2'b01;
   localparam logic [1:0] RF_PC1 = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_NAND  = 2'b01;
   localparam logic [1:0] ALU_PASSB = 2'b10;
   localparam logic [1:0] ALU_SUB   = 2'b11;

   function automatic logic [2:0] opcode(input logic [15:0] ir);
      return ir[15:13];
   endfunction

   // A JALR with a non-zero immediate field is the HALT encoding.
   function automatic logic is_halt(input logic [15:0] ir);
      return (ir[15:13] == OP_JALR) && (ir[6:0] != 7'd0);
   endfunction

endpackage

// File: rtl/risc16_ctrl_if.sv
// Instruction / data memory handshake bundle between the RiSC-16 controller
// (master) and the memory system (slave).
interface risc16_ctrl_if;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/risc16_ack_timer.sv
// Saturating wait counter for memory handshakes; flags expiry on the waiting cycle that
// brings the count to ACK_TIMEOUT. ACK_TIMEOUT = 0 disables expiry.
module risc16_ack_timer #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam bit          Enabled  = (ACK_TIMEOUT != 0);
   localparam int unsigned CntW     = Enabled ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam int unsigned LastWait = Enabled ? ACK_TIMEOUT - 1 : 0;
   localparam logic [CntW-1:0] CntMax  = CntW'(ACK_TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(LastWait);

   logic [CntW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (waiting && (r_cnt != CntMax)) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   assign expired = Enabled && waiting && (r_cnt >= CntLast);

endmodule

// File: rtl/risc16_ctrl.sv
// Multi-cycle RiSC-16 control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes and
// ack timeout. Define RISC16_HALT_EN to treat JALR with a non-zero immediate as HALT.
module risc16_ctrl
   import risc16_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset,
   risc16_ctrl_if.master       mem,
   output logic [15:0]         ir_out,
   input  logic                alu_zero,
   output logic                pc_en,
   output logic [1:0]          pc_sel,
   output logic                rf_we,
   output logic [1:0]          rf_wsel,
   output logic [1:0]          alu_op,
   output logic                alu_srcb,
   output logic                halted,
   output logic                err
);

   state_e      r_state;
   logic [15:0] r_ir;
   logic        r_imem_req;
   logic        r_dmem_req;

   logic [2:0]  w_op;
   logic        w_iack;
   logic        w_dack;
   logic        w_waiting;
   logic        w_clear;
   logic        w_expired;
   logic        w_is_halt;

   assign w_op   = opcode(r_ir);
   // Acks only count while our own request is outstanding.
   assign w_iack = r_imem_req & mem.imem_ack;
   assign w_dack = r_dmem_req & mem.dmem_ack;

   assign w_waiting = ((r_state == StFetch) & r_imem_req & ~mem.imem_ack) |
                      ((r_state == StMem)   & r_dmem_req & ~mem.dmem_ack);
   assign w_clear   = ~w_waiting;

`ifdef RISC16_HALT_EN
   assign w_is_halt = is_halt(r_ir);
   assign halted    = (r_state == StHalt);
`else
   assign w_is_halt = 1'b0;
   assign halted    = 1'b0;
`endif

   risc16_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .waiting (w_waiting),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StFetch;
         r_ir       <= '0;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
      end else begin
         unique case (r_state)
            StFetch: begin
               if (w_expired) begin
                  r_state    <= StError;
                  r_imem_req <= 1'b0;
               end else if (w_iack) begin
                  r_ir       <= mem.imem_rdata;
                  r_imem_req <= 1'b0;
                  r_state    <= StDecode;
               end else begin
                  r_imem_req <= 1'b1;
               end
            end
            StDecode: r_state <= StExec;
            StExec: begin
               case (w_op)
                  OP_SW, OP_LW: begin
                     r_state    <= StMem;
                     r_dmem_req <= 1'b1;
                  end
                  OP_BEQ: begin
                     r_state    <= StFetch;
                     r_imem_req <= 1'b1;
                  end
                  OP_JALR: begin
                     if (w_is_halt) begin
                        r_state <= StHalt;
                     end else begin
                        r_state    <= StFetch;
                        r_imem_req <= 1'b1;
                     end
                  end
                  default: r_state <= StWb;
               endcase
            end
            StMem: begin
               if (w_expired) begin
                  r_state    <= StError;
                  r_dmem_req <= 1'b0;
               end else if (w_dack) begin
                  r_dmem_req <= 1'b0;
                  if (w_op == OP_LW) begin
                     r_state <= StWb;
                  end else begin
                     r_state    <= StFetch;
                     r_imem_req <= 1'b1;
                  end
               end
            end
            StWb: begin
               r_state    <= StFetch;
               r_imem_req <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pc_en    = 1'b0;
      pc_sel   = PC_PLUS1;
      rf_we    = 1'b0;
      rf_wsel  = RF_ALU;
      alu_op   = ALU_ADD;
      alu_srcb = 1'b0;
      case (r_state)
         StExec: begin
            case (w_op)
               OP_ADD: ;
               OP_ADDI: alu_srcb = 1'b1;
               OP_NAND: alu_op = ALU_NAND;
               OP_LUI: begin
                  alu_op   = ALU_PASSB;
                  alu_srcb = 1'b1;
               end
               OP_SW, OP_LW: alu_srcb = 1'b1;
               OP_BEQ: begin
                  alu_op = ALU_SUB;
                  pc_en  = 1'b1;
                  pc_sel = alu_zero ? PC_PLUS1_IMM : PC_PLUS1;
               end
               OP_JALR: begin
                  if (!w_is_halt) begin
                     alu_srcb = 1'b1;
                     rf_we    = 1'b1;
                     rf_wsel  = RF_PC1;
                     pc_en    = 1'b1;
                     pc_sel   = PC_ALU;
                  end
               end
            endcase
         end
         // Stores retire on the ack cycle itself; loads retire in WB.
         StMem: pc_en = w_dack & (w_op == OP_SW);
         StWb: begin
            rf_we   = 1'b1;
            rf_wsel = (w_op == OP_LW) ? RF_MEM : RF_ALU;
            pc_en   = 1'b1;
         end
         default: ;
      endcase
   end

   assign ir_out       = r_ir;
   assign mem.imem_req = r_imem_req;
   assign mem.dmem_req = r_dmem_req;
   assign mem.dmem_we  = r_dmem_req & (w_op == OP_SW);
   assign err          = (r_state == StError);

endmodule

// File: doc/risc16_ctrl.md
# risc16_ctrl

Multi-cycle control FSM for the RiSC-16 core. Sequences every instruction through fetch, decode, execute, memory and write-back, handshakes with instruction and data memory, and drives the PC register's next-value select and write enable, the register-file write controls and the ALU controls. It sits between the memories and the datapath. The PC register updates only on cycles where `pc_en` is high.

## Interface
- `ACK_TIMEOUT`, default 255: maximum cycles to wait for `imem_ack`/`dmem_ack`; 0 disables the timeout.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: instruction fetch request, level.
- `imem_ack` in 1: fetch data valid on `imem_rdata`.
- `imem_rdata` in 16: fetched instruction.
- `ir_out` out 16: latched instruction register.
- `alu_zero` in 1: ALU equality result, used by BEQ.
- `dmem_req` out 1: data memory request, level.
- `dmem_we` out 1: store when high, load when low; valid while `dmem_req` is high.
- `dmem_ack` in 1: data access complete.
- `pc_en` out 1: PC write enable.
- `pc_sel` out 2: 00 = pc+1, 01 = pc+1+imm, 10 = alu_result.
- `rf_we` out 1: register-file write enable.
- `rf_wsel` out 2: write-data select. 00 = ALU, 01 = memory data, 10 = pc+1.
- `alu_op` out 2: 00 = ADD, 01 = NAND, 10 = pass-B (LUI), 11 = SUB/compare.
- `alu_srcb` out 1: 0 = rC, 1 = immediate.
- `halted` out 1: core stopped by HALT.
- `err` out 1: sticky memory-timeout error.

## Operation
- Opcode is `ir_out[15:13]`: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR.
- FETCH
  - Hold `imem_req` high until `imem_ack`.
  - On ack, latch `imem_rdata` into `ir_out` and go to DECODE.
- DECODE: one cycle for register read, then EXEC.
- EXEC, ADD/ADDI/NAND/LUI: drive `alu_op`/`alu_srcb`, then WB.
- EXEC, LW/SW: `alu_op`=00, `alu_srcb`=1 (address), then MEM.
- EXEC, BEQ
  - `alu_op`=11, `pc_en`=1, `pc_sel` = `alu_zero` ? 01 : 00.
  - Then FETCH.
- EXEC, JALR
  - `rf_we`=1 with `rf_wsel`=10.
  - `pc_en`=1 with `pc_sel`=10.
  - Then FETCH.
- MEM
  - Hold `dmem_req` high, with `dmem_we` = (opcode==SW), until `dmem_ack`.
  - LW: go to WB.
  - SW: on ack, `pc_en`=1 with `pc_sel`=00, then FETCH.
- WB
  - `rf_we`=1; `rf_wsel` = 01 for LW, else 00.
  - `pc_en`=1 with `pc_sel`=00.
  - Then FETCH.
- `pc_en` pulses exactly once per retired instruction.
- `rf_we` never asserts for SW or BEQ.
- Timeout
  - While waiting in FETCH or MEM, a wait counter increments each cycle without ack.
  - When it reaches `ACK_TIMEOUT`, go to ERROR with `err`=1. ERROR issues no requests.
  - The counter clears on ack or on state change.
- HALT and ERROR are terminal until `reset`.

## Timing
- Reset values:
  - All outputs 0, including `ir_out`=0x0000.
  - Wait counter 0.
  - State FETCH; `imem_req` rises the first clock after reset deasserts.
- Reset mid-handshake: requests drop immediately (asynchronously), and any pending ack is ignored.
- Outputs decode from state, plus `ir_out`, `alu_zero` and ack (Mealy on ack only for `pc_en` in MEM).
- Ack handling:
  - An ack arriving in the same cycle as the request completes that access.
  - Acks while no request is pending are ignored.
  - The request deasserts the cycle after ack.
- CPI with single-cycle acks: ALU ops 4, LW 5, SW 4, BEQ 3, JALR 3.
- Each extra wait cycle adds one.

## Configuration
- `RISC16_HALT_EN`, defined:
  - JALR with `ir_out[6:0]` != 0 is HALT.
  - In EXEC: no writes, no `pc_en`; go to HALT and assert `halted`.
- Not defined: every JALR executes as a normal JALR, and `halted` is tied to 0.

## Structure
- Shared package `risc16_pkg`:
  - opcode localparams
  - FSM state enum
  - `pc_sel` encodings (PC_PLUS1, PC_PLUS1_IMM, PC_ALU)
  - `rf_wsel` encodings
  - `alu_op` encodings
- Sub-module `risc16_ack_timer`:
  - Ports: `ACK_TIMEOUT` parameter, `clear`, `waiting`, `expired`.
  - Counter width is `$clog2(ACK_TIMEOUT+1)`; the counter saturates.

## Test plan
- ADDI 0x2481 with single-cycle acks: `pc_en` pulses once in cycle 4 with `pc_sel`=00; `rf_we`=1 and `rf_wsel`=00 in WB.
- LW with `dmem_ack` delayed 3 cycles: `dmem_req` high for 4 cycles with `dmem_we`=0; WB has `rf_wsel`=01; the instruction takes 8 cycles total.
- BEQ taken vs. not taken:
  - `alu_zero`=1 in EXEC gives `pc_sel`=01 with `pc_en`=1.
  - `alu_zero`=0 gives `pc_sel`=00.
  - Both take 3 cycles.
- JALR 0xE080 (imm 0): `rf_wsel`=10 and `pc_sel`=10 in the same EXEC cycle. With the macro, 0xE071 enters HALT, `halted`=1, and there are no further requests.
- `ACK_TIMEOUT`=4 with `imem_ack` never asserted: ERROR after 4 waiting cycles, `err`=1, `imem_req`=0. A later `imem_ack` has no effect; `reset` clears everything.
- Reset asserted mid-MEM: `dmem_req` drops the same cycle; after release, FETCH restarts with `ir_out`=0.
